sc_mux_scanner: RTL and testbench

SC_MUX_SCANNER -- requirements
Module: sc_mux_scanner

---
 rtl/sc_mux_scanner.sv | 231 +++++++++++++++++++++++
 tb/tb_sc_mux_scanner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mux_scanner.sv
// -----------------------------------------------------------------------------
// sc_mux_scanner
//   Drives the select code of a downstream N:1 mux, waits a programmable
//   settle time on each selected channel, then captures the mux output.
//   Channels are visited in ascending order over a mask latched at start,
//   either as a single sweep (ends with a Done pulse) or continuously until
//   Stop.
//
// Parameters
//   DATAWIDTH_MUX_SELECTION : select-code width (2**W channels, default 8)
//   DATAWIDTH_BUS           : captured data width
//   DWELL_CYCLES            : settle cycles after each select change (1..255)
//
// Ports
//   SC_MUXSCAN_CLOCK_50       in  : clock, rising edge
//   SC_MUXSCAN_RESET_InHigh   in  : asynchronous active-high reset
//   SC_MUXSCAN_Start_In       in  : start request (honoured only in IDLE)
//   SC_MUXSCAN_Stop_In        in  : abort request (honoured in SETTLE/CAPTURE)
//   SC_MUXSCAN_Continuous_In  in  : 0 = single sweep, 1 = endless round-robin
//   SC_MUXSCAN_ChannelMask_In in  : per-channel enable, latched at start
//   SC_MUXSCAN_Selection_Out  out : registered mux select code
//   SC_MUXSCAN_DataBUS_In     in  : mux output returned to this block
//   SC_MUXSCAN_DataBUS_Out    out : last captured sample
//   SC_MUXSCAN_Channel_Out    out : channel number of DataBUS_Out
//   SC_MUXSCAN_Valid_Out      out : one-cycle capture pulse
//   SC_MUXSCAN_Done_Out       out : one-cycle sweep-complete pulse
//   SC_MUXSCAN_Busy_Out       out : high while a scan is active
// -----------------------------------------------------------------------------
module sc_mux_scanner #(
  parameter int DATAWIDTH_MUX_SELECTION = 3,
  parameter int DATAWIDTH_BUS           = 8,
  parameter int DWELL_CYCLES            = 4
) (
  input  logic                                SC_MUXSCAN_CLOCK_50,
  input  logic                                SC_MUXSCAN_RESET_InHigh,
  input  logic                                SC_MUXSCAN_Start_In,
  input  logic                                SC_MUXSCAN_Stop_In,
  input  logic                                SC_MUXSCAN_Continuous_In,
  input  logic [(1<<DATAWIDTH_MUX_SELECTION)-1:0] SC_MUXSCAN_ChannelMask_In,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]  SC_MUXSCAN_Selection_Out,
  input  logic [DATAWIDTH_BUS-1:0]            SC_MUXSCAN_DataBUS_In,
  output logic [DATAWIDTH_BUS-1:0]            SC_MUXSCAN_DataBUS_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]  SC_MUXSCAN_Channel_Out,
  output logic                                SC_MUXSCAN_Valid_Out,
  output logic                                SC_MUXSCAN_Done_Out,
  output logic                                SC_MUXSCAN_Busy_Out
);

  localparam int SW     = DATAWIDTH_MUX_SELECTION;
  localparam int NUM_CH = 1 << SW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Registered state and outputs
  state_t                   r_state;
  logic [7:0]               r_count;
  logic [NUM_CH-1:0]        r_mask;
  logic                     r_continuous;
  logic [SW-1:0]            r_sel;
  logic [DATAWIDTH_BUS-1:0] r_data;
  logic [SW-1:0]            r_channel;
  logic                     r_valid;
  logic                     r_done;
  logic                     r_busy;

  // Next-state values
  state_t                   w_state_next;
  logic [7:0]               w_count_next;
  logic [NUM_CH-1:0]        w_mask_next;
  logic                     w_continuous_next;
  logic [SW-1:0]            w_sel_next;
  logic [DATAWIDTH_BUS-1:0] w_data_next;
  logic [SW-1:0]            w_channel_next;
  logic                     w_valid_next;
  logic                     w_done_next;
  logic                     w_busy_next;

  logic [SW-1:0]            w_next_ch;
  logic [SW-1:0]            w_first_ch;
  logic                     w_wrap;
  logic                     w_dwell_done;

  // First enabled channel searching upward from cur+1, wrapping modulo
  // NUM_CH. With a single enabled channel equal to cur, the search lands on
  // cur itself after a full lap.
  function automatic logic [SW-1:0] f_next_channel(input logic [NUM_CH-1:0] mask,
                                                   input logic [SW-1:0]     cur);
    logic [SW-1:0] idx;
    logic          found;
    f_next_channel = cur;
    found          = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur + SW'(i);
      if (!found && mask[idx]) begin
        f_next_channel = idx;
        found          = 1'b1;
      end
    end
  endfunction

  // Searching "after" the top channel yields the lowest enabled channel.
  assign w_first_ch   = f_next_channel(SC_MUXSCAN_ChannelMask_In, {SW{1'b1}});
  assign w_next_ch    = f_next_channel(r_mask, r_sel);
  assign w_wrap       = (w_next_ch <= r_sel);
  assign w_dwell_done = (r_count == 8'(DWELL_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge SC_MUXSCAN_CLOCK_50 or posedge SC_MUXSCAN_RESET_InHigh) begin
    if (SC_MUXSCAN_RESET_InHigh) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_mask       <= '0;
      r_continuous <= 1'b0;
      r_sel        <= '0;
      r_data       <= '0;
      r_channel    <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_mask       <= w_mask_next;
      r_continuous <= w_continuous_next;
      r_sel        <= w_sel_next;
      r_data       <= w_data_next;
      r_channel    <= w_channel_next;
      r_valid      <= w_valid_next;
      r_done       <= w_done_next;
      r_busy       <= w_busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (SC_MUXSCAN_Start_In && (|SC_MUXSCAN_ChannelMask_In))
          w_state_next = SETTLE;
      end
      SETTLE: begin
        if (SC_MUXSCAN_Stop_In)  w_state_next = IDLE;
        else if (w_dwell_done)   w_state_next = CAPTURE;
      end
      CAPTURE: begin
        if (SC_MUXSCAN_Stop_In)                w_state_next = IDLE;
        else if (!r_continuous && w_wrap)      w_state_next = IDLE;
        else                                   w_state_next = SETTLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic (values registered at the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_count_next      = r_count;
    w_mask_next       = r_mask;
    w_continuous_next = r_continuous;
    w_sel_next        = r_sel;
    w_data_next       = r_data;
    w_channel_next    = r_channel;
    w_valid_next      = 1'b0;
    w_done_next       = 1'b0;
    w_busy_next       = r_busy;

    case (r_state)
      IDLE: begin
        if (SC_MUXSCAN_Start_In && (|SC_MUXSCAN_ChannelMask_In)) begin
          w_mask_next       = SC_MUXSCAN_ChannelMask_In;
          w_continuous_next = SC_MUXSCAN_Continuous_In;
          w_sel_next        = w_first_ch;
          w_count_next      = '0;
          w_busy_next       = 1'b1;
        end
      end
      SETTLE: begin
        if (SC_MUXSCAN_Stop_In) begin
          w_busy_next  = 1'b0;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end
      CAPTURE: begin
        // Stop wins over the capture that would otherwise happen this edge.
        if (SC_MUXSCAN_Stop_In) begin
          w_busy_next  = 1'b0;
          w_count_next = '0;
        end else begin
          w_data_next    = SC_MUXSCAN_DataBUS_In;
          w_channel_next = r_sel;
          w_valid_next   = 1'b1;
          if (!r_continuous && w_wrap) begin
            // Sweep complete: select code is left on the last channel.
            w_done_next = 1'b1;
            w_busy_next = 1'b0;
          end else begin
            w_sel_next   = w_next_ch;
            w_count_next = '0;
          end
        end
      end
      default: begin
        w_busy_next = 1'b0;
      end
    endcase
  end

  assign SC_MUXSCAN_Selection_Out = r_sel;
  assign SC_MUXSCAN_DataBUS_Out   = r_data;
  assign SC_MUXSCAN_Channel_Out   = r_channel;
  assign SC_MUXSCAN_Valid_Out     = r_valid;
  assign SC_MUXSCAN_Done_Out      = r_done;
  assign SC_MUXSCAN_Busy_Out      = r_busy;

endmodule

// File: tb/tb_sc_mux_scanner.sv
// -----------------------------------------------------------------------------
// tb_sc_mux_scanner
//   Self-checking bench for sc_mux_scanner. The downstream mux is modelled as
//   a per-channel data table indexed by the DUT select code. Expected capture
//   sequences come from the mask (ascending enabled channels) and the timing
//   rule "one capture every DWELL+1 cycles after the start edge".
// -----------------------------------------------------------------------------
module tb_sc_mux_scanner;

  localparam int SW    = 3;
  localparam int BW    = 8;
  localparam int DWELL = 4;
  localparam int PER   = DWELL + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          cont;
  logic [7:0]    mask_in;
  logic [SW-1:0] sel;
  logic [BW-1:0] data_in;
  logic [BW-1:0] data_out;
  logic [SW-1:0] ch_out;
  logic          valid;
  logic          done;
  logic          busy;

  logic [BW-1:0] chan_data [8];

  int checks = 0;
  int errors = 0;

  // Capture log (edge index relative to the start edge)
  int            q_ch   [$];
  logic [BW-1:0] q_data [$];
  int            q_cyc  [$];
  int            q_done [$];

  always #5 clk = ~clk;

  // Downstream 8:1 mux
  assign data_in = chan_data[sel];

  sc_mux_scanner #(
    .DATAWIDTH_MUX_SELECTION (SW),
    .DATAWIDTH_BUS           (BW),
    .DWELL_CYCLES            (DWELL)
  ) dut (
    .SC_MUXSCAN_CLOCK_50       (clk),
    .SC_MUXSCAN_RESET_InHigh   (rst),
    .SC_MUXSCAN_Start_In       (start),
    .SC_MUXSCAN_Stop_In        (stop),
    .SC_MUXSCAN_Continuous_In  (cont),
    .SC_MUXSCAN_ChannelMask_In (mask_in),
    .SC_MUXSCAN_Selection_Out  (sel),
    .SC_MUXSCAN_DataBUS_In     (data_in),
    .SC_MUXSCAN_DataBUS_Out    (data_out),
    .SC_MUXSCAN_Channel_Out    (ch_out),
    .SC_MUXSCAN_Valid_Out      (valid),
    .SC_MUXSCAN_Done_Out       (done),
    .SC_MUXSCAN_Busy_Out       (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    q_ch.delete(); q_data.delete(); q_cyc.delete(); q_done.delete();
    for (int r = 1; r <= n; r++) begin
      tick();
      if (valid) begin
        q_ch.push_back(int'(ch_out));
        q_data.push_back(data_out);
        q_cyc.push_back(r);
      end
      if (done) q_done.push_back(r);
    end
  endtask

  task automatic do_start(input logic [7:0] m, input logic c);
    mask_in = m;
    cont    = c;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic randomize_data();
    for (int c = 0; c < 8; c++) chan_data[c] = 8'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask_in = '0;
    for (int c = 0; c < 8; c++) chan_data[c] = '0;
    #12;
    checks++;
    if ({sel, data_out, ch_out, valid, done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%0h data=%0h ch=%0h v=%0b d=%0b b=%0b required all 0",
               sel, data_out, ch_out, valid, done, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  // Generic single sweep over mask m; expectations from the mask alone.
  task automatic test_single_sweep(input string name, input logic [7:0] m);
    int exp_ch [$];
    int n;
    for (int c = 0; c < 8; c++) if (m[c]) exp_ch.push_back(c);
    n = exp_ch.size();
    do_start(m, 1'b0);
    checks++;
    if (sel !== SW'(exp_ch[0]) || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: got sel=%0d busy=%0b required sel=%0d busy=1", name, sel, busy, exp_ch[0]);
    end
    collect(PER * n + 5);
    checks++;
    if (q_ch.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d captures required %0d", name, q_ch.size(), n);
    end
    for (int k = 0; k < n && k < q_ch.size(); k++) begin
      checks++;
      if (q_ch[k] != exp_ch[k] || q_data[k] !== chan_data[exp_ch[k]] || q_cyc[k] != PER * (k + 1)) begin
        errors++;
        $display("FAIL %s_capture%0d: got ch=%0d data=%0h edge=%0d required ch=%0d data=%0h edge=%0d",
                 name, k, q_ch[k], q_data[k], q_cyc[k], exp_ch[k], chan_data[exp_ch[k]], PER * (k + 1));
      end
    end
    checks++;
    if (q_done.size() != 1 || (q_done.size() == 1 && q_done[0] != PER * n)) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses first at %0d required 1 pulse at %0d",
               name, q_done.size(), (q_done.size() > 0) ? q_done[0] : -1, PER * n);
    end
    checks++;
    if (busy !== 1'b0 || sel !== SW'(exp_ch[n-1])) begin
      errors++;
      $display("FAIL %s_end: got busy=%0b sel=%0d required busy=0 sel=%0d", name, busy, sel, exp_ch[n-1]);
    end
  endtask

  task automatic test_full_sweep();
    randomize_data();
    test_single_sweep("full_sweep", 8'hFF);
  endtask

  task automatic test_sparse_mask();
    for (int c = 0; c < 8; c++) chan_data[c] = 8'h10 + 8'(c);
    test_single_sweep("sparse", 8'b1010_0100);
  endtask

  task automatic test_continuous_stop();
    logic [BW-1:0] last;
    randomize_data();
    do_start(8'b1000_0001, 1'b1);
    mask_in = 8'hFF; cont = 1'b0;  // ignored while busy
    collect(6 * PER);
    checks++;
    if (q_ch.size() != 6 || q_done.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cont_run: got %0d captures %0d done busy=%0b required 6 captures 0 done busy=1",
               q_ch.size(), q_done.size(), busy);
    end
    for (int k = 0; k < 6 && k < q_ch.size(); k++) begin
      checks++;
      if (q_ch[k] != ((k % 2) ? 7 : 0) || q_cyc[k] != PER * (k + 1)) begin
        errors++;
        $display("FAIL cont_seq%0d: got ch=%0d edge=%0d required ch=%0d edge=%0d",
                 k, q_ch[k], q_cyc[k], (k % 2) ? 7 : 0, PER * (k + 1));
      end
    end
    // Now in SETTLE on channel 0: stop.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: got busy=%0b v=%0b d=%0b required 0 0 0", busy, valid, done);
    end
    last = data_out;
    collect(4 * PER);
    checks++;
    if (q_ch.size() != 0 || q_done.size() != 0 || busy !== 1'b0 || last !== chan_data[7]) begin
      errors++;
      $display("FAIL cont_after_stop: got %0d captures %0d done busy=%0b data=%0h required 0 0 0 %0h",
               q_ch.size(), q_done.size(), busy, last, chan_data[7]);
    end
  endtask

  task automatic test_stop_in_capture();
    logic [BW-1:0] prev;
    randomize_data();
    prev = data_out;
    chan_data[0] = ~prev;
    do_start(8'hFF, 1'b0);
    collect(DWELL);  // now in CAPTURE on channel 0
    checks++;
    if (q_ch.size() != 0) begin
      errors++;
      $display("FAIL stopcap_early: got %0d captures required 0", q_ch.size());
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || data_out !== prev) begin
      errors++;
      $display("FAIL stopcap: got v=%0b d=%0b b=%0b data=%0h required 0 0 0 %0h",
               valid, done, busy, data_out, prev);
    end
    collect(2 * PER);
    checks++;
    if (q_ch.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stopcap_after: got %0d captures busy=%0b required 0 0", q_ch.size(), busy);
    end
  endtask

  task automatic test_zero_mask_and_mask_change();
    logic [SW-1:0] psel;
    logic [BW-1:0] pdata;
    logic [SW-1:0] pch;
    psel = sel; pdata = data_out; pch = ch_out;
    stop = 1'b1;           // stop in IDLE: ignored
    tick();
    stop = 1'b0;
    do_start(8'h00, 1'b0); // zero mask: ignored
    collect(3 * PER);
    checks++;
    if (busy !== 1'b0 || q_ch.size() != 0 || q_done.size() != 0 ||
        sel !== psel || data_out !== pdata || ch_out !== pch) begin
      errors++;
      $display("FAIL zero_mask: got busy=%0b caps=%0d done=%0d sel=%0d data=%0h ch=%0d required 0 0 0 %0d %0h %0d",
               busy, q_ch.size(), q_done.size(), sel, data_out, ch_out, psel, pdata, pch);
    end
    // Mid-scan mask/mode change and Start held high while busy.
    randomize_data();
    do_start(8'b0000_0110, 1'b0);
    mask_in = 8'h00; cont = 1'b1; start = 1'b1;
    collect(2 * PER + 5);
    start = 1'b0; cont = 1'b0;
    checks++;
    if (q_ch.size() != 2 || q_done.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mask_change: got caps=%0d done=%0d busy=%0b required 2 1 0",
               q_ch.size(), q_done.size(), busy);
    end
    for (int k = 0; k < 2 && k < q_ch.size(); k++) begin
      checks++;
      if (q_ch[k] != k + 1 || q_data[k] !== chan_data[k + 1] || q_cyc[k] != PER * (k + 1)) begin
        errors++;
        $display("FAIL mask_change_cap%0d: got ch=%0d data=%0h edge=%0d required ch=%0d data=%0h edge=%0d",
                 k, q_ch[k], q_data[k], q_cyc[k], k + 1, chan_data[k + 1], PER * (k + 1));
      end
    end
    if (q_done.size() == 1) begin
      checks++;
      if (q_done[0] != 2 * PER) begin
        errors++;
        $display("FAIL mask_change_done: got edge %0d required %0d", q_done[0], 2 * PER);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    randomize_data();
    do_start(8'hFF, 1'b0);
    collect(12);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sel, data_out, ch_out, valid, done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: got sel=%0h data=%0h ch=%0h v=%0b d=%0b b=%0b required all 0",
               sel, data_out, ch_out, valid, done, busy);
    end
    rst = 1'b0;
    randomize_data();
    test_single_sweep("after_reset", 8'hFF);
  endtask

  task automatic test_random_sweeps();
    for (int it = 0; it < 6; it++) begin
      randomize_data();
      test_single_sweep("random", 8'($urandom_range(1, 255)));
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_sparse_mask();
    test_continuous_stop();
    test_stop_in_capture();
    test_zero_mask_and_mask_change();
    test_reset_mid_scan();
    test_random_sweeps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
